// File: rtl/prng_arbiter_if.sv
// prng_arbiter_if -- bundle between the requesters, the PRNG core and
// prng_arbiter.
//
// Parameters: NREQ requesters, WIDTH-bit random/seed words.
// Signals:
//   req[NREQ]        level request for one random word per requester
//   gnt[NREQ]        one-hot, one-cycle grant; rand_data/err valid with it
//   rand_data[WIDTH] word delivered with gnt
//   err              grant ended by timeout (rand_data is the old word)
//   seed_req         level reseed request
//   seed_data[WIDTH] seed, sampled when the arbiter accepts seed_req
//   seed_ack         one-cycle acknowledge of an accepted reseed
//   prng_step        one-cycle pulse advancing the core
//   prng_load        one-cycle pulse loading prng_seed into the core
//   prng_seed[WIDTH] seed presented to the core, valid while prng_load is high
//   prng_value[WIDTH] current core output
//   prng_ready       core output updated after a step
//
// Handshake semantics: req and seed_req are levels; a request is consumed
// when the arbiter answers it with exactly one gnt (or seed_ack) pulse, and a
// requester still holding req after that pulse is asking for another word.
// prng_ready is only meaningful while the arbiter is waiting after prng_step.
//
// Modports: slave = arbiter side, master = requester/core side.
interface prng_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] rand_data;
    logic             err;
    logic             seed_req;
    logic [WIDTH-1:0] seed_data;
    logic             seed_ack;
    logic             prng_step;
    logic             prng_load;
    logic [WIDTH-1:0] prng_seed;
    logic [WIDTH-1:0] prng_value;
    logic             prng_ready;

    modport slave (
        input  req, seed_req, seed_data, prng_value, prng_ready,
        output gnt, rand_data, err, seed_ack, prng_step, prng_load, prng_seed
    );

    modport master (
        output req, seed_req, seed_data, prng_value, prng_ready,
        input  gnt, rand_data, err, seed_ack, prng_step, prng_load, prng_seed
    );
endinterface

// File: rtl/prng_arbiter.sv
// prng_arbiter -- shares one PRNG core among NREQ requesters with round-robin
// arbitration, reseeding, and a timeout on the core's ready.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-low reset
//   bus              prng_arbiter_if.slave (requests, grants, core control)
//   grant_count_o    16-bit total grants (0 unless PRNG_ARBITER_STATS_EN)
//   timeout_count_o  8-bit total timeout grants (0 unless PRNG_ARBITER_STATS_EN)
//   state_dbg_o      current FSM state (IDLE=0 STEP=1 WAIT=2 GRANT=3 SEED=4)
//
// Optional feature: define PRNG_ARBITER_STATS_EN to build the grant and
// timeout counters; otherwise both outputs are tied to zero.
module prng_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    prng_arbiter_if.slave       bus,
    output logic [15:0]         grant_count_o,
    output logic [7:0]          timeout_count_o,
    output logic [2:0]          state_dbg_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP  = 3'd1,
        S_WAIT  = 3'd2,
        S_GRANT = 3'd3,
        S_SEED  = 3'd4
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    win_q;
    logic [7:0]       wait_cnt_q;
    logic [NREQ-1:0]  gnt_q;
    logic [WIDTH-1:0] rand_q;
    logic             err_q;
    logic             ack_q;
    logic             step_q;
    logic             load_q;
    logic [WIDTH-1:0] seed_q;

    // Round-robin search: scan upward from ptr_q, wrapping at NREQ.
    logic [IW-1:0]    win_d;
    logic             found_d;
    logic [IW:0]      scan_sum;
    logic [IW-1:0]    scan_idx;

    always_comb begin
        win_d    = '0;
        found_d  = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (scan_sum >= (IW+1)'(NREQ)) begin
                scan_sum = scan_sum - (IW+1)'(NREQ);
            end
            scan_idx = scan_sum[IW-1:0];
            if (!found_d && bus.req[scan_idx]) begin
                found_d = 1'b1;
                win_d   = scan_idx;
            end
        end
    end

    logic [NREQ-1:0] win_onehot;
    assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            wait_cnt_q <= '0;
            gnt_q      <= '0;
            rand_q     <= '0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            step_q     <= 1'b0;
            load_q     <= 1'b0;
            seed_q     <= '0;
        end else begin
            // Pulse outputs default low so each is high for one cycle only.
            gnt_q  <= '0;
            err_q  <= 1'b0;
            ack_q  <= 1'b0;
            step_q <= 1'b0;
            load_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Reseed wins over word requests, but only here in IDLE.
                    if (bus.seed_req) begin
                        seed_q  <= bus.seed_data;
                        load_q  <= 1'b1;
                        ack_q   <= 1'b1;
                        state_q <= S_SEED;
                    end else if (found_d) begin
                        win_q   <= win_d;
                        step_q  <= 1'b1;
                        state_q <= S_STEP;
                    end
                end
                S_STEP: begin
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.prng_ready) begin
                        rand_q  <= bus.prng_value;
                        gnt_q   <= win_onehot;
                        state_q <= S_GRANT;
                    end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
                        // Give up: grant with the previous word and flag it.
                        gnt_q   <= win_onehot;
                        err_q   <= 1'b1;
                        state_q <= S_GRANT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                S_GRANT: begin
                    ptr_q   <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                    state_q <= S_IDLE;
                end
                S_SEED: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rand_data = rand_q;
    assign bus.err       = err_q;
    assign bus.seed_ack  = ack_q;
    assign bus.prng_step = step_q;
    assign bus.prng_load = load_q;
    assign bus.prng_seed = seed_q;
    assign state_dbg_o   = state_q;

`ifdef PRNG_ARBITER_STATS_EN
    logic [15:0] grant_cnt_q;
    logic [7:0]  timeout_cnt_q;

    // GRANT lasts exactly one cycle, so counting there counts each gnt pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt_q   <= '0;
            timeout_cnt_q <= '0;
        end else if (state_q == S_GRANT) begin
            grant_cnt_q <= grant_cnt_q + 16'd1;
            if (err_q) begin
                timeout_cnt_q <= timeout_cnt_q + 8'd1;
            end
        end
    end

    assign grant_count_o   = grant_cnt_q;
    assign timeout_count_o = timeout_cnt_q;
`else
    assign grant_count_o   = 16'd0;
    assign timeout_count_o = 8'd0;
`endif
endmodule

// File: tb/tb_prng_arbiter.sv
// tb_prng_arbiter -- directed bench for prng_arbiter (NREQ=4, WIDTH=32,
// TIMEOUT=15). Inputs change on the falling edge, outputs are sampled there.
module tb_prng_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int TO    = 15;

`ifdef PRNG_ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    prng_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
    logic [15:0] gc;
    logic [7:0]  tc;
    logic [2:0]  st;

    prng_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .grant_count_o   (gc),
        .timeout_count_o (tc),
        .state_dbg_o     (st)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the FSM in IDLE and req already driven.
    // Walks STEP, WAIT (ready or timeout), GRANT and back to IDLE.
    task automatic get_word(input string tag, input logic [3:0] exp_gnt,
                            input logic [31:0] val, input bit ready_en,
                            input logic [31:0] exp_rand);
        int n;
        @(negedge clk);
        check({tag, " step"}, {bus.prng_step, bus.gnt, st}, {1'b1, 4'b0000, 3'd1});
        @(negedge clk);
        check({tag, " wait"}, {bus.prng_step, bus.gnt, st}, {1'b0, 4'b0000, 3'd2});
        if (ready_en) begin
            bus.prng_value = val;
            bus.prng_ready = 1'b1;
            @(negedge clk);
            bus.prng_ready = 1'b0;
        end else begin
            n = 0;
            while (bus.gnt == 4'b0000 && n < TO + 5) begin
                @(negedge clk);
                n++;
            end
            check({tag, " timeout cycles"}, 64'(n), 64'(TO));
        end
        check({tag, " gnt"}, bus.gnt, exp_gnt);
        check({tag, " rand"}, bus.rand_data, exp_rand);
        check({tag, " err"}, bus.err, !ready_en);
        check({tag, " state grant"}, st, 3'd3);
        @(negedge clk);
        check({tag, " back idle"}, {bus.gnt, bus.err, st}, {4'b0000, 1'b0, 3'd0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req        = '0;
        bus.seed_req   = 1'b0;
        bus.seed_data  = '0;
        bus.prng_value = '0;
        bus.prng_ready = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        check("rst gnt", bus.gnt, 4'b0000);
        check("rst rand", bus.rand_data, 32'h0);
        check("rst pulses", {bus.err, bus.seed_ack, bus.prng_step, bus.prng_load}, 4'b0000);
        check("rst seed", bus.prng_seed, 32'h0);
        check("rst counts", {gc, tc}, 24'h0);
        check("rst state", st, 3'd0);

        // single requester, core ready one cycle after step
        rst     = 1'b1;
        bus.req = 4'b0001;
        get_word("t1", 4'b0001, 32'h12345678, 1'b1, 32'h12345678);
        bus.req = 4'b0000;

        // reseed and word request together: reseed goes first
        bus.seed_req  = 1'b1;
        bus.seed_data = 32'hdeadbeef;
        bus.req       = 4'b0100;
        @(negedge clk);
        check("seed pulses", {bus.prng_load, bus.seed_ack, bus.prng_step, bus.gnt}, {3'b110, 4'b0000});
        check("seed value", bus.prng_seed, 32'hdeadbeef);
        check("seed state", st, 3'd4);
        bus.seed_req  = 1'b0;
        bus.seed_data = 32'h0;
        @(negedge clk);
        check("seed one cycle", {bus.prng_load, bus.seed_ack, st}, {2'b00, 3'd0});
        get_word("t3", 4'b0100, 32'hcafef00d, 1'b1, 32'hcafef00d);
        bus.req = 4'b0000;

        // timeout: ptr=3, req=0010 -> winner 1, old word kept
        bus.req = 4'b0010;
        get_word("t4", 4'b0010, 32'h0, 1'b0, 32'hcafef00d);
        bus.req = 4'b0000;

        // ptr=2, req=1011 -> winner 3
        bus.req = 4'b1011;
        get_word("t5", 4'b1000, 32'h0badf00d, 1'b1, 32'h0badf00d);
        bus.req = 4'b0000;

        // ptr wrapped to 0, req=0011 -> winner 0
        bus.req = 4'b0011;
        get_word("t6", 4'b0001, 32'h55aa33cc, 1'b1, 32'h55aa33cc);
        bus.req = 4'b0000;
        check("stats grants", gc, STATS ? 16'd5 : 16'd0);
        check("stats timeouts", tc, STATS ? 8'd1 : 8'd0);

        // reset during WAIT (ptr=1, winner 2)
        bus.req = 4'b0100;
        @(negedge clk);
        check("rw step", {bus.prng_step, st}, {1'b1, 3'd1});
        bus.req = 4'b0000;
        @(negedge clk);
        check("rw wait", st, 3'd2);
        rst = 1'b0;
        #1;
        check("rw outputs", {bus.gnt, bus.err, bus.seed_ack, bus.prng_step, bus.prng_load}, 8'h00);
        check("rw rand", bus.rand_data, 32'h0);
        check("rw seed", bus.prng_seed, 32'h0);
        check("rw counts", {gc, tc}, 24'h0);
        check("rw state", st, 3'd0);
        repeat (2) @(negedge clk);
        check("rw no gnt", bus.gnt, 4'b0000);

        // all four held after reset: strict rotation starting at requester 0
        bus.req = 4'b1111;
        rst     = 1'b1;
        get_word("rr0", 4'b0001, 32'h00000011, 1'b1, 32'h00000011);
        get_word("rr1", 4'b0010, 32'h00000022, 1'b1, 32'h00000022);
        get_word("rr2", 4'b0100, 32'h00000033, 1'b1, 32'h00000033);
        get_word("rr3", 4'b1000, 32'h00000044, 1'b1, 32'h00000044);
        get_word("rr4", 4'b0001, 32'h00000055, 1'b1, 32'h00000055);
        bus.req = 4'b0000;
        check("final grants", gc, STATS ? 16'd5 : 16'd0);
        check("final timeouts", tc, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/prng_arbiter.md
PRNG_ARBITER -- requirements
Module: prng_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one PRNG core, range 2-8.
REQ-002 Parameter WIDTH, default 32: random/seed word width.
REQ-003 Parameter TIMEOUT, default 15: maximum cycles spent waiting for prng_ready, range 1-255.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester request for one random word, level.
REQ-007 gnt  output  NREQ  one-hot, one-cycle grant; rand_data is valid in the same cycle.
REQ-008 rand_data  output  WIDTH  registered word delivered with gnt.
REQ-009 err  output  1  high with gnt when that grant ended by timeout.
REQ-010 seed_req  input  1  reseed request, level.
REQ-011 seed_data  input  WIDTH  seed value, sampled when the arbiter accepts seed_req.
REQ-012 seed_ack  output  1  one-cycle acknowledge of an accepted reseed.
REQ-013 prng_step  output  1  one-cycle pulse that advances the core.
REQ-014 prng_load  output  1  one-cycle pulse that loads prng_seed into the core.
REQ-015 prng_seed  output  WIDTH  seed presented to the core, valid while prng_load is high.
REQ-016 prng_value  input  WIDTH  current core output.
REQ-017 prng_ready  input  1  core signals that prng_value has been updated after a step.
REQ-018 grant_count  output  16  total grants issued (see Configuration).
REQ-019 timeout_count  output  8  total timeouts (see Configuration).

Function
REQ-020 The FSM SHALL have the states IDLE, STEP, WAIT, GRANT and SEED, with all outputs registered.
REQ-021 IDLE: seed_req high -> SEED; else any req bit high -> latch the winner, go to STEP; else stay in IDLE.
REQ-022 Seed requests have priority over random-word requests, but only when evaluated in IDLE; an operation in progress is never preempted.
REQ-023 SEED: prng_load=1, prng_seed=seed_data as captured at acceptance, seed_ack=1 for exactly one cycle, then IDLE.
REQ-024 Winner selection is round-robin: the search starts at pointer ptr and scans upward with wrap at NREQ; the first requester with req set wins.
REQ-025 After each grant, ptr = (winner+1) mod NREQ; a seed operation does not change ptr.
REQ-026 STEP: prng_step=1 for one cycle, clear the wait counter, go to WAIT.
REQ-027 WAIT: prng_ready sampled high -> capture prng_value into rand_data, err=0, go to GRANT.
REQ-028 WAIT: TIMEOUT cycles without prng_ready -> keep the previous rand_data, set err=1, go to GRANT.
REQ-029 GRANT: gnt[winner]=1 for exactly one cycle, then IDLE.
REQ-030 Minimum latency: req sampled at edge N -> prng_step high in cycle N+1 -> with prng_ready high in cycle N+2, gnt is high in cycle N+3.
REQ-031 The grant is issued even if the winner drops req after selection; a requester holding req receives one grant per word.
REQ-032 prng_ready is ignored outside WAIT.
REQ-033 A requester that holds req continuously is re-arbitrated in the IDLE cycle that follows GRANT.

Reset
REQ-034 While rst is low: state=IDLE, ptr=0, gnt=0, rand_data=0, err=0, seed_ack=0, prng_step=0, prng_load=0, prng_seed=0, grant_count=0, timeout_count=0.
REQ-035 Reset mid-operation abandons the operation without issuing a grant; the first grant after reset is evaluated with ptr=0.

Configuration
REQ-036 Macro PRNG_ARBITER_STATS_EN defined: grant_count increments on every gnt pulse and timeout_count increments on every err grant, both wrapping modulo 2^16 and 2^8 respectively.
REQ-037 Macro undefined: grant_count and timeout_count are constant 0 and no counter registers are built.

Verification
REQ-038 req=0001; core returns 32'h12345678 with prng_ready one cycle after prng_step -> gnt=0001 for one cycle, rand_data=32'h12345678, err=0, gnt at the fourth edge.
REQ-039 req=1111 held -> grant order 0001, 0010, 0100, 1000, 0001, with no gnt gaps beyond the FSM latency.
REQ-040 In IDLE, seed_req=1 with seed_data=32'hdeadbeef and req=0100 -> prng_load with prng_seed=32'hdeadbeef and seed_ack first, then gnt=0100.
REQ-041 req=0010 with prng_ready held low -> gnt=0010 with err=1 TIMEOUT cycles after WAIT entry; rand_data unchanged.
REQ-042 rst low during WAIT -> all outputs 0 immediately, no gnt; after release, req=1111 -> first gnt=0001.
REQ-043 With PRNG_ARBITER_STATS_EN defined, 5 grants including 1 timeout -> grant_count=5, timeout_count=1; without the macro both are 0.
